// File: rtl/c17_bist_driver.sv
// BIST driver for the mapped C17 netlist: pattern source, MISR compactor
// and golden-signature compare around the CUT pad interface.
module c17_bist_driver #(
    parameter int              PATTERN_MODE = 0,
    parameter int              NUM_PATTERNS = 32,
    parameter logic [4:0]      LFSR_SEED    = 5'h01,
    parameter int              CUT_LATENCY  = 0,
    parameter int              SIG_W        = 16,
    parameter logic [SIG_W-1:0] MISR_POLY   = SIG_W'(16'h1021),
    parameter logic [SIG_W-1:0] GOLDEN_SIG  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [4:0]       cut_in,
    input  logic [1:0]       cut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [5:0]       pattern_idx
);

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        DRAIN,
        DONE
    } state_t;

    localparam logic [4:0] SEED =
        (LFSR_SEED == 5'd0) ? 5'd1 : LFSR_SEED;
    localparam logic [4:0] FIRST =
        (PATTERN_MODE != 0) ? SEED : 5'd0;
    localparam logic [5:0] NP       = 6'(NUM_PATTERNS);
    localparam logic [5:0] LAST_IDX = 6'(NUM_PATTERNS - 1);
    localparam int         DW       = (CUT_LATENCY > 0) ? CUT_LATENCY : 1;
    localparam logic [1:0] DRN_LAST = 2'(DW - 1);

    state_t           state_q, state_d;
    logic [4:0]       pat_q, pat_d, pat_next;
    logic [SIG_W-1:0] sig_q, sig_d, misr_next, sig_cap;
    logic [5:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [1:0]       drn_q, drn_d;
    logic             issue;
    logic             cap;

    assign issue = (state_q == APPLY);

    generate
        if (CUT_LATENCY == 0) begin : g_direct
            assign cap = issue;
        end else begin : g_pipe
            logic [CUT_LATENCY-1:0] vld_q;

            // valid bit travels alongside each pattern through the CUT
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q <= '0;
                end else if (abort) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= (vld_q << 1) | CUT_LATENCY'(issue);
                end
            end

            assign cap = vld_q[CUT_LATENCY-1];
        end
    endgenerate

    // next state, next pattern, MISR compaction and result flags
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sig_d   = sig_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        drn_d   = drn_q;

        misr_next = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? MISR_POLY : '0)
                  ^ {{(SIG_W-2){1'b0}}, cut_out};
        sig_cap   = cap ? misr_next : sig_q;

        if (PATTERN_MODE != 0) begin
            pat_next = {pat_q[3:0], pat_q[4] ^ pat_q[2]};
        end else begin
            pat_next = pat_q + 5'd1;
        end

        if (abort) begin
            state_d = IDLE;
            pat_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            drn_d   = '0;
        end else begin
            sig_d = sig_cap;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = APPLY;
                        pat_d   = FIRST;
                        sig_d   = '0;
                        idx_d   = '0;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                    end
                end
                APPLY: begin
                    if (idx_q != NP) begin
                        idx_d = idx_q + 6'd1;
                    end
                    if (idx_q == LAST_IDX) begin
                        pat_d = '0;
                        if (CUT_LATENCY > 0) begin
                            state_d = DRAIN;
                            drn_d   = DRN_LAST;
                        end else begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = (sig_cap == GOLDEN_SIG);
                        end
                    end else begin
                        pat_d = pat_next;
                    end
                end
                DRAIN: begin
                    if (drn_q == 2'd0) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (sig_cap == GOLDEN_SIG);
                    end else begin
                        drn_d = drn_q - 2'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= '0;
            sig_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            drn_q   <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sig_q   <= sig_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            drn_q   <= drn_d;
        end
    end

    assign cut_in      = pat_q;
    assign signature   = sig_q;
    assign pattern_idx = idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_c17_bist_driver.sv
// Bench for c17_bist_driver: fixed traces on small configurations,
// random CUT responses checked against a pattern/signature model.
module tb_c17_bist_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [5:0] start;
    logic [5:0] abort;
    logic [4:0] cin [6];
    logic [1:0] cout [6];
    logic [5:0] busy, done, pass;
    logic [15:0] sig [5];
    logic [7:0] sig5;
    logic [5:0] idx [6];
    logic [1:0] tab4 [32];
    logic [1:0] tab5 [32];

    int nchk = 0;
    int npass = 0;

    typedef struct {
        int          inst;
        int          cyc;
        logic [4:0]  cin;
        logic        busy;
        logic        done;
        logic        pass;
        logic [15:0] sig;
        logic [5:0]  idx;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [1:0] c17(input logic [4:0] p);
        logic n10, n11, n16, n19;
        n10 = ~(p[0] & p[2]);
        n11 = ~(p[2] & p[3]);
        n16 = ~(p[1] & n11);
        n19 = ~(n11 & p[4]);
        return {~(n16 & n19), ~(n10 & n16)};
    endfunction

    function automatic logic [4:0] gen_pat(input bit lfsr,
                                           input logic [4:0] seed,
                                           input int k);
        int unsigned p;
        if (!lfsr) return 5'(k);
        p = (seed == 5'd0) ? 1 : int'(seed);
        repeat (k) p = ((p << 1) | (((p >> 4) ^ (p >> 2)) & 1)) & 31;
        return 5'(p);
    endfunction

    function automatic logic [15:0] ref_sig(input bit lfsr, input int n,
                                            input logic [4:0] seed,
                                            input int w,
                                            input int unsigned poly,
                                            input logic [1:0] tab [32]);
        int unsigned s, m, top, r;
        s = 0;
        m = (32'd1 << w) - 1;
        for (int k = 0; k < n; k++) begin
            top = (s >> (w - 1)) & 1;
            r = int'(tab[gen_pat(lfsr, seed, k)]);
            s = ((s << 1) ^ ((top != 0) ? poly : 0) ^ r) & m;
        end
        return 16'(s);
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            npass++;
    endtask

    task automatic add(input int i, input int c, input logic [4:0] ci,
                       input logic b, input logic d, input logic p,
                       input logic [15:0] s, input logic [5:0] x);
        vec_t e;
        e.inst = i; e.cyc = c; e.cin = ci; e.busy = b;
        e.done = d; e.pass = p; e.sig = s; e.idx = x;
        tbl.push_back(e);
    endtask

    function automatic logic [29:0] obs(input int i);
        return {cin[i], busy[i], done[i], pass[i], sig[i], idx[i]};
    endfunction

    // counter, N=3, golden 3, combinational C17
    c17_bist_driver #(.PATTERN_MODE(0), .NUM_PATTERNS(3),
                      .GOLDEN_SIG(16'h0003)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .cut_in(cin[0]), .cut_out(cout[0]), .busy(busy[0]),
        .done(done[0]), .pass(pass[0]), .signature(sig[0]),
        .pattern_idx(idx[0]));
    assign cout[0] = c17(cin[0]);

    // counter, N=4, golden 3 (expected to fail compare)
    c17_bist_driver #(.PATTERN_MODE(0), .NUM_PATTERNS(4),
                      .GOLDEN_SIG(16'h0003)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .cut_in(cin[1]), .cut_out(cout[1]), .busy(busy[1]),
        .done(done[1]), .pass(pass[1]), .signature(sig[1]),
        .pattern_idx(idx[1]));
    assign cout[1] = c17(cin[1]);

    // LFSR with zero seed, N=4
    c17_bist_driver #(.PATTERN_MODE(1), .NUM_PATTERNS(4),
                      .LFSR_SEED(5'h00)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
        .cut_in(cin[2]), .cut_out(cout[2]), .busy(busy[2]),
        .done(done[2]), .pass(pass[2]), .signature(sig[2]),
        .pattern_idx(idx[2]));
    assign cout[2] = c17(cin[2]);

    // counter, N=3, 2-stage registered CUT
    c17_bist_driver #(.PATTERN_MODE(0), .NUM_PATTERNS(3),
                      .CUT_LATENCY(2), .GOLDEN_SIG(16'h0003)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .abort(abort[3]),
        .cut_in(cin[3]), .cut_out(cout[3]), .busy(busy[3]),
        .done(done[3]), .pass(pass[3]), .signature(sig[3]),
        .pattern_idx(idx[3]));
    logic [1:0] p3a = 2'b0, p3b = 2'b0;
    always @(posedge clk) begin
        p3a <= c17(cin[3]);
        p3b <= p3a;
    end
    assign cout[3] = p3b;

    // LFSR, N=31, 3-stage CUT with random response table
    c17_bist_driver #(.PATTERN_MODE(1), .NUM_PATTERNS(31),
                      .LFSR_SEED(5'h0B), .CUT_LATENCY(3)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start[4]), .abort(abort[4]),
        .cut_in(cin[4]), .cut_out(cout[4]), .busy(busy[4]),
        .done(done[4]), .pass(pass[4]), .signature(sig[4]),
        .pattern_idx(idx[4]));
    logic [1:0] d4a = 2'b0, d4b = 2'b0, d4c = 2'b0;
    always @(posedge clk) begin
        d4a <= tab4[cin[4]];
        d4b <= d4a;
        d4c <= d4b;
    end
    assign cout[4] = d4c;

    // counter, N=32, 8-bit MISR, 1-stage CUT with random table
    c17_bist_driver #(.PATTERN_MODE(0), .NUM_PATTERNS(32),
                      .CUT_LATENCY(1), .SIG_W(8), .MISR_POLY(8'h1D),
                      .GOLDEN_SIG(8'hA5)) u5 (
        .clk(clk), .rst_n(rst_n), .start(start[5]), .abort(abort[5]),
        .cut_in(cin[5]), .cut_out(cout[5]), .busy(busy[5]),
        .done(done[5]), .pass(pass[5]), .signature(sig5),
        .pattern_idx(idx[5]));
    logic [1:0] d5 = 2'b0;
    always @(posedge clk) d5 <= tab5[cin[5]];
    assign cout[5] = d5;

    task automatic rand_run(input int r);
        logic [15:0] e4, e5;
        int b4, b5;
        for (int i = 0; i < 32; i++) begin
            tab4[i] = 2'($urandom);
            tab5[i] = 2'($urandom);
        end
        e4 = ref_sig(1'b1, 31, 5'h0B, 16, 32'h1021, tab4);
        e5 = ref_sig(1'b0, 32, 5'h00, 8, 32'h1D, tab5);
        b4 = 0;
        b5 = 0;
        @(posedge clk); #1;
        start[5:4] = 2'b11;
        @(posedge clk); #1;
        start[5:4] = 2'b00;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (busy[4] && busy[5] && $urandom_range(0, 3) == 0)
                start[5:4] = 2'b11;
            else
                start[5:4] = 2'b00;
            @(negedge clk);
            if (busy[4]) b4++;
            if (busy[5]) b5++;
            if (cyc <= 31)
                chk($sformatf("r%0d u4 pat%0d", r, cyc), 64'(cin[4]),
                    64'(gen_pat(1'b1, 5'h0B, cyc - 1)));
            if (cyc <= 32)
                chk($sformatf("r%0d u5 pat%0d", r, cyc), 64'(cin[5]),
                    64'(gen_pat(1'b0, 5'h00, cyc - 1)));
            @(posedge clk); #1;
        end
        start[5:4] = 2'b00;
        chk($sformatf("r%0d u4 busy cycles", r), 64'(b4), 64'd34);
        chk($sformatf("r%0d u5 busy cycles", r), 64'(b5), 64'd33);
        chk($sformatf("r%0d u4 sig", r), 64'(sig[4]), 64'(e4));
        chk($sformatf("r%0d u5 sig", r), 64'(sig5), 64'(e5[7:0]));
        chk($sformatf("r%0d u4 done/pass/idx", r),
            {done[4], pass[4], idx[4]}, {1'b1, e4 == 16'h0, 6'd31});
        chk($sformatf("r%0d u5 done/pass/idx", r),
            {done[5], pass[5], idx[5]}, {1'b1, e5[7:0] == 8'hA5, 6'd32});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = '0;
        abort = '0;
        for (int i = 0; i < 32; i++) begin
            tab4[i] = 2'b0;
            tab5[i] = 2'b0;
        end

        // inst, cyc, cut_in, busy, done, pass, sig, idx
        add(0, 0, 5'h00, 0, 0, 0, 16'h0, 0);
        add(0, 1, 5'h00, 1, 0, 0, 16'h0, 0);
        add(0, 2, 5'h01, 1, 0, 0, 16'h0, 1);
        add(0, 3, 5'h02, 1, 0, 0, 16'h0, 2);
        add(0, 4, 5'h00, 0, 1, 1, 16'h3, 3);
        add(0, 5, 5'h00, 0, 1, 1, 16'h3, 3);
        add(1, 0, 5'h00, 0, 0, 0, 16'h0, 0);
        add(1, 1, 5'h00, 1, 0, 0, 16'h0, 0);
        add(1, 2, 5'h01, 1, 0, 0, 16'h0, 1);
        add(1, 3, 5'h02, 1, 0, 0, 16'h0, 2);
        add(1, 4, 5'h03, 1, 0, 0, 16'h3, 3);
        add(1, 5, 5'h00, 0, 1, 0, 16'h5, 4);
        add(1, 6, 5'h00, 0, 1, 0, 16'h5, 4);
        add(2, 0, 5'h00, 0, 0, 0, 16'h0, 0);
        add(2, 1, 5'h01, 1, 0, 0, 16'h0, 0);
        add(2, 2, 5'h02, 1, 0, 0, 16'h0, 1);
        add(2, 3, 5'h04, 1, 0, 0, 16'h3, 2);
        add(2, 4, 5'h09, 1, 0, 0, 16'h6, 3);
        add(2, 5, 5'h00, 0, 1, 0, 16'hC, 4);
        add(3, 0, 5'h00, 0, 0, 0, 16'h0, 0);
        add(3, 1, 5'h00, 1, 0, 0, 16'h0, 0);
        add(3, 2, 5'h01, 1, 0, 0, 16'h0, 1);
        add(3, 3, 5'h02, 1, 0, 0, 16'h0, 2);
        add(3, 4, 5'h00, 1, 0, 0, 16'h0, 3);
        add(3, 5, 5'h00, 1, 0, 0, 16'h0, 3);
        add(3, 6, 5'h00, 0, 1, 1, 16'h3, 3);

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(posedge clk); #1;
        start[3:0] = 4'hF;
        for (int c = 0; c <= 6; c++) begin
            @(negedge clk);
            foreach (tbl[j])
                if (tbl[j].cyc == c)
                    chk($sformatf("vec u%0d c%0d", tbl[j].inst, c),
                        64'(obs(tbl[j].inst)),
                        64'({tbl[j].cin, tbl[j].busy, tbl[j].done,
                             tbl[j].pass, tbl[j].sig, tbl[j].idx}));
            @(posedge clk); #1;
            start = '0;
        end

        // abort together with start in the second APPLY cycle
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort pre cut_in", 64'(cin[0]), 64'd1);
        abort[0] = 1'b1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        start[0] = 1'b0;
        @(negedge clk);
        chk("abort flags", {busy[0], done[0], pass[0]}, 3'b000);
        chk("abort cut_in", 64'(cin[0]), 64'd0);
        chk("abort sig hold", 64'(sig[0]), 64'd0);
        @(posedge clk); #1;
        chk("abort stays idle", 64'(busy[0]), 64'd0);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rerun done/pass/busy", {done[0], pass[0], busy[0]}, 3'b110);
        chk("rerun sig", 64'(sig[0]), 64'h3);

        // asynchronous reset in the middle of an APPLY phase
        @(posedge clk); #1;
        start[4] = 1'b1;
        @(posedge clk); #1;
        start[4] = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("reset u4 outputs",
            {cin[4], busy[4], done[4], pass[4], sig[4], idx[4]}, 64'd0);
        chk("reset u0 outputs", {done[0], pass[0], sig[0]}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 3; r++) rand_run(r);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
